shared_reg_arbiter: RTL
=======================

Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared WIDTH-bit register built from resettable D flip-flops.
- NREQ requesters compete for write ownership.
- The winner holds a one-hot grant and may write the register for up to MAX_BURST consecutive cycles.
- Sits between requester logic and the shared state register; the output q is the register contents.

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, width of shared register and each write-data lane
MAX_BURST, 4, max writes per grant (>=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester write request; bit i = requester i
wdata  input  NREQ*WIDTH  write data; lane i = wdata[i*WIDTH +: WIDTH]
gnt  output  NREQ  registered one-hot grant, all-zero when idle
owner  output  $clog2(NREQ)  index of current/last grantee
busy  output  1  high while a grant is held
q  output  WIDTH  shared register contents

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, gnt=0, busy=0, owner=0, q=0.
  - Round-robin pointer ptr=0; burst counter cnt=0.
  - Applies immediately, including mid-burst.
- States: IDLE, GRANT.
- IDLE, at a clock edge with any req bit high:
  - Select the first requester with req=1, scanning ptr, ptr+1, ... with wrap mod NREQ.
  - Next state GRANT; gnt[sel]=1, owner=sel, busy=1, cnt=0.
  - No write to q on this edge.
  - Latency: req high before edge E -> gnt high after E; first write to q at edge E+1.
- IDLE with req=0: hold all outputs; q retains its value.
- GRANT, at each edge:
  - If req[owner]=1:
    - q<=wdata lane owner; cnt<=cnt+1.
    - If cnt==MAX_BURST-1, this write is the last: release.
  - If req[owner]=0: no write, release.
  - Release means:
    - gnt=0, busy=0, state=IDLE.
    - ptr=(owner+1) mod NREQ.
    - owner keeps its value.
- Gap between grants: at least one cycle with gnt=0. Back-to-back ownership by the same requester is allowed only if no other requester is pending per the round-robin scan.
- Non-owner req and wdata are ignored during GRANT. Requests are not queued; the requester keeps req high until granted.
- q is written only in GRANT with req[owner]=1; otherwise q holds.
- Invariants: gnt is always zero or one-hot; busy == |gnt; cnt never exceeds MAX_BURST-1.
- Simultaneous requests: the round-robin scan decides; no fixed priority beyond ptr.
- Fairness: a requester holding req continuously is granted within NREQ-1 other grants.

Test Plan:
1. Reset behaviour: hold reset=0 for 2 cycles with req=4'b1111 -> gnt=0, busy=0, q=8'h00, owner=0. Deassert reset -> gnt=4'b0001 after the next edge.
2. Single burst: req=4'b0100 with lane2=8'hA5 for 2 cycles after the grant, then drop -> gnt=4'b0100 for exactly 3 cycles. q=8'hA5 after the first GRANT edge. ptr=3, and q holds 8'hA5.
3. Burst cap (MAX_BURST=4): req[1] held high with lane1 = 8'h10, 8'h11, 8'h12, 8'h13, 8'h14 on successive edges -> 4 writes, q=8'h13. gnt drops after the 4th write. One idle cycle, then regrant to requester 1 if it is the only requester.
4. Round robin: req=4'b1111 held, each owner capped -> grant order 0,1,2,3,0, with gnt=0 for one cycle between each grant.
5. Reset mid-burst: pull reset low asynchronously between edges during a grant to requester 3 -> gnt=0, busy=0, q=0 immediately, without waiting for a clock edge. The first grant after release goes to requester 0.
6. Ignored requester: requester 0 is the owner, and requester 2 asserts req with lane2=8'hFF -> q never takes 8'hFF until requester 2 is granted.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
//
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// NREQ requesters compete for write ownership. The winner holds a registered
// one-hot grant. It may write the register on up to MAX_BURST consecutive
// edges, as long as it keeps its request high.
//
// Handshake: a requester raises req[i] and keeps it high until gnt[i] is seen.
// The grant edge itself never writes q. Each following edge with req[owner]=1
// writes lane 'owner' into q. Dropping req[owner], or reaching the burst cap,
// releases the grant. After a release there is always at least one cycle with
// gnt=0 before the next grant.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   req    - per-requester write request, bit i = requester i
//   wdata  - write data, lane i = wdata[i*WIDTH +: WIDTH]
//   gnt    - registered one-hot grant, all-zero when idle
//   owner  - index of the current or most recent grantee
//   busy   - high while a grant is held (equals |gnt)
//   q      - shared register contents
// -----------------------------------------------------------------------------
module shared_reg_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q
);

    localparam int OW = $clog2(NREQ);
    // Keep the counter at least one bit wide when MAX_BURST is 1.
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NREQ-1:0]     gnt_q,   gnt_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic                busy_q,  busy_d;
    logic [WIDTH-1:0]    q_q,     q_d;
    logic [OW-1:0]       ptr_q,   ptr_d;
    logic [CW-1:0]       cnt_q,   cnt_d;

    logic                found;
    logic [OW-1:0]       sel;
    logic                owner_req;
    logic [WIDTH-1:0]    owner_lane;
    logic [OW-1:0]       next_ptr;

    // Round-robin scan: ptr, ptr+1, ... wrapping modulo NREQ. The first hit wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = OW'(idx);
            end
        end
    end

    // Request and data lane of the current owner.
    always_comb begin
        owner_req  = 1'b0;
        owner_lane = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OW'(i)) begin
                owner_req  = req[i];
                owner_lane = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign next_ptr = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        q_d     = q_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                    owner_d    = sel;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                end
            end

            GRANT: begin
                // A release happens when the owner stops requesting, or after
                // its MAX_BURST-th write. The counter is cleared on release, so
                // it never holds a value above MAX_BURST-1.
                if (owner_req) begin
                    q_d   = owner_lane;
                    cnt_d = cnt_q + CW'(1);
                end
                if (!owner_req || (cnt_q == CW'(MAX_BURST - 1))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_ptr;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            q_q     <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign q     = q_q;

endmodule
